// File: rtl/neureka_stream_demux_sched_pkg.sv
// neureka_stream_demux_sched_pkg: shared types and channel-rotation helper for the load-stream demux scheduler
package neureka_stream_demux_sched_pkg;
  localparam int unsigned MAX_CH = 8;
  localparam int unsigned MAX_CW = 3;
  localparam int unsigned MAX_LENW = 16;
  typedef enum logic {SCHED_STATIC = 1'b0, SCHED_INTERLEAVE = 1'b1} sched_mode_e;
  typedef struct packed {
    logic start;
    sched_mode_e mode;
    logic [MAX_CW-1:0] sel;
    logic [MAX_CH-1:0] ch_mask;
    logic [MAX_LENW-1:0] burst_len;
    logic [MAX_LENW-1:0] tot_len;
  } demux_sched_ctrl_t;
  typedef struct packed {
    logic busy;
    logic done;
    logic [MAX_CW-1:0] cur_ch;
    logic [MAX_CH-1:0] fifo_empty;
    logic [MAX_CH-1:0] fifo_full;
  } demux_sched_flags_t;
  // Next set bit strictly above cur, wrapping; returns cur when it is the only candidate.
  function automatic logic [MAX_CW-1:0] next_ch(input logic [MAX_CH-1:0] mask, input logic [MAX_CW-1:0] cur);
    logic [MAX_CW-1:0] r;
    logic [MAX_CW-1:0] idx;
    logic hit;
    r = cur;
    hit = 1'b0;
    for (int i = 1; i <= int'(MAX_CH); i++) begin
      idx = cur + MAX_CW'(i);
      if (!hit && mask[idx]) begin
        r = idx;
        hit = 1'b1;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/neureka_stream_demux_sched_if.sv
// neureka_stream_demux_sched_if: shared push stream and per-channel pop streams of the demux scheduler
interface neureka_stream_demux_sched_if #(
  parameter int unsigned DW = 288,
  parameter int unsigned NB_CH = 4
);
  logic [DW-1:0] push_data;
  logic [DW/8-1:0] push_strb;
  logic push_valid;
  logic push_ready;
  logic [NB_CH*DW-1:0] pop_data;
  logic [NB_CH*DW/8-1:0] pop_strb;
  logic [NB_CH-1:0] pop_valid;
  logic [NB_CH-1:0] pop_ready;
  modport master (
    output push_data, push_strb, push_valid, pop_ready,
    input push_ready, pop_data, pop_strb, pop_valid
  );
  modport slave (
    input push_data, push_strb, push_valid, pop_ready,
    output push_ready, pop_data, pop_strb, pop_valid
  );
endinterface

// File: rtl/neureka_stream_demux_sched_chan_fifo.sv
// neureka_stream_demux_sched_chan_fifo: single-channel registered data/strobe FIFO with sync clear
module neureka_stream_demux_sched_chan_fifo #(
  parameter int unsigned DW = 288,
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic push_i,
  input  logic [DW-1:0] data_i,
  input  logic [DW/8-1:0] strb_i,
  input  logic pop_i,
  output logic [DW-1:0] data_o,
  output logic [DW/8-1:0] strb_o,
  output logic full_o,
  output logic empty_o
);
  localparam int unsigned AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  logic [DW+DW/8-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CNTW-1:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == CNTW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i & ~full_o;
  assign do_pop = pop_i & ~empty_o;
  // An empty FIFO presents zeros so stale entries never leak onto the bus.
  assign {data_o, strb_o} = empty_o ? '0 : mem_q[rd_q];
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= {data_i, strb_i};
      if (do_push) wr_q <= wr_q == AW'(DEPTH - 1) ? '0 : wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q == AW'(DEPTH - 1) ? '0 : rd_q + AW'(1);
      cnt_q <= cnt_q + CNTW'(do_push) - CNTW'(do_pop);
    end
  end
endmodule

// File: rtl/neureka_stream_demux_sched.sv
// neureka_stream_demux_sched: N-way load-stream demux with per-channel FIFOs, static/interleaved burst scheduling and job tracking
module neureka_stream_demux_sched
  import neureka_stream_demux_sched_pkg::*;
#(
  parameter int unsigned DW = 288,
  parameter int unsigned NB_CH = 4,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned LENW = 16,
  parameter int unsigned CW = $clog2(NB_CH)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  input  logic start_i,
  input  logic mode_i,
  input  logic [CW-1:0] sel_i,
  input  logic [NB_CH-1:0] ch_mask_i,
  input  logic [LENW-1:0] burst_len_i,
  input  logic [LENW-1:0] tot_len_i,
  neureka_stream_demux_sched_if.slave bus,
  output logic [CW-1:0] cur_ch_o,
  output logic busy_o,
  output logic done_o,
  output logic [NB_CH-1:0] fifo_empty_o,
  output logic [NB_CH-1:0] fifo_full_o
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
  logic [1:0] state_q, state_d;
  sched_mode_e mode_q, mode_d;
  logic [LENW-1:0] tot_q, tot_d, blen_q, blen_d, beat_q, beat_d, burst_q, burst_d;
  logic [CW-1:0] cur_q, cur_d, nxt_ch, first_ch;
  logic [NB_CH-1:0] full, empty, push_k, pop_k;
  logic [MAX_CH-1:0] mask8;
  logic ch_ok, accept, last_beat, last_burst, start_ok, all_empty;
  assign mask8 = MAX_CH'(ch_mask_i);
  assign nxt_ch = CW'(next_ch(mask8, MAX_CW'(cur_q)));
  assign first_ch = CW'(next_ch(mask8, MAX_CW'(MAX_CH - 1)));
  assign ch_ok = mode_q == SCHED_STATIC || ch_mask_i[cur_q];
  // Full comes from registered occupancy, so a pop on a full FIFO cannot admit a beat the same cycle.
  assign bus.push_ready = enable_i & (state_q == RUN) & ~full[cur_q] & ch_ok;
  assign accept = bus.push_ready & bus.push_valid;
  assign last_beat = beat_q == tot_q - LENW'(1);
  assign last_burst = burst_q == blen_q - LENW'(1);
  assign start_ok = start_i && tot_len_i != '0 && !(mode_i && ch_mask_i == '0);
  assign all_empty = &empty;
  assign done_o = enable_i & (state_q == DRAIN) & all_empty;
  assign busy_o = state_q != IDLE;
  assign cur_ch_o = cur_q;
  assign fifo_empty_o = empty;
  assign fifo_full_o = full;
  assign bus.pop_valid = {NB_CH{enable_i}} & ~empty;
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    tot_d = tot_q;
    blen_d = blen_q;
    beat_d = beat_q;
    burst_d = burst_q;
    cur_d = cur_q;
    if (enable_i && state_q == IDLE && start_ok) begin
      state_d = RUN;
      mode_d = mode_i ? SCHED_INTERLEAVE : SCHED_STATIC;
      tot_d = tot_len_i;
      blen_d = burst_len_i == '0 ? LENW'(1) : burst_len_i;
      beat_d = '0;
      burst_d = '0;
      cur_d = mode_i ? first_ch : sel_i;
    end else if (enable_i && state_q == RUN) begin
      beat_d = accept ? beat_q + LENW'(1) : beat_q;
      state_d = accept && last_beat ? DRAIN : RUN;
      if (mode_q == SCHED_STATIC) begin
        cur_d = sel_i;
      end else if (!ch_mask_i[cur_q]) begin
        cur_d = nxt_ch;
        burst_d = '0;
      end else if (accept) begin
        cur_d = last_burst ? nxt_ch : cur_q;
        burst_d = last_burst ? '0 : burst_q + LENW'(1);
      end
    end else if (enable_i && state_q == DRAIN && all_empty) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= IDLE;
      mode_q <= SCHED_STATIC;
      tot_q <= '0;
      blen_q <= '0;
      beat_q <= '0;
      burst_q <= '0;
      cur_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      tot_q <= tot_d;
      blen_q <= blen_d;
      beat_q <= beat_d;
      burst_q <= burst_d;
      cur_q <= cur_d;
    end
  end
  for (genvar k = 0; k < NB_CH; k++) begin : g_ch
    assign push_k[k] = accept & (cur_q == CW'(k));
    assign pop_k[k] = bus.pop_valid[k] & bus.pop_ready[k];
    neureka_stream_demux_sched_chan_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) i_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (clear_i),
      .push_i (push_k[k]),
      .data_i (bus.push_data),
      .strb_i (bus.push_strb),
      .pop_i  (pop_k[k]),
      .data_o (bus.pop_data[k*DW +: DW]),
      .strb_o (bus.pop_strb[k*(DW/8) +: DW/8]),
      .full_o (full[k]),
      .empty_o(empty[k])
    );
  end
endmodule

// File: tb/tb_neureka_stream_demux_sched.sv
// tb_neureka_stream_demux_sched: table-driven cycle vectors with a per-channel data model, plus hand-written corner sequences
module tb_neureka_stream_demux_sched;
  localparam int DW = 32;
  localparam int NB = 4;
  logic clk = 1'b0;
  logic rst, clear, enable, start, mode;
  logic [1:0] sel, cur_ch;
  logic [3:0] mask, f_empty, f_full;
  logic [15:0] blen, tot;
  logic busy, done;
  neureka_stream_demux_sched_if #(.DW(DW), .NB_CH(NB)) bus();
  neureka_stream_demux_sched #(.DW(DW), .NB_CH(NB), .FIFO_DEPTH(2), .LENW(16)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable), .start_i(start),
    .mode_i(mode), .sel_i(sel), .ch_mask_i(mask), .burst_len_i(blen), .tot_len_i(tot),
    .bus(bus), .cur_ch_o(cur_ch), .busy_o(busy), .done_o(done),
    .fifo_empty_o(f_empty), .fifo_full_o(f_full)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic clr, en, st, md;
    logic [1:0] sel;
    logic [3:0] mask;
    logic [15:0] blen, tot;
    logic pv;
    logic [3:0] pr;
    logic e_rdy;
    logic [3:0] e_val;
    logic [1:0] e_ch;
    logic e_busy, e_done;
  } vec_t;
  vec_t vecs[$];
  logic [DW+DW/8-1:0] q [NB][$];
  int checks = 0;
  int errors = 0;
  logic [31:0] nb = 0;
  task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask
  task automatic add(input int clr, en, st, md, sl, mk, bl, tt, pv, pr, rdy, val, ch, bsy, dn);
    vecs.push_back('{1'(clr), 1'(en), 1'(st), 1'(md), 2'(sl), 4'(mk), 16'(bl), 16'(tt), 1'(pv), 4'(pr),
                     1'(rdy), 4'(val), 2'(ch), 1'(bsy), 1'(dn)});
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t v;
    logic seen;
    rst = 1; clear = 0; enable = 1; start = 0; mode = 0; sel = 0; mask = 0; blen = 0; tot = 0;
    bus.push_valid = 1; bus.pop_ready = 4'hF; bus.push_data = '0; bus.push_strb = '0;
    // STATIC sel=2 tot=5
    add(0,1,1,0,2,0,0,5,1,'hF, 0,'b0000,0,0,0);
    add(0,1,0,0,2,0,0,5,1,'hF, 1,'b0000,2,1,0);
    for (int i = 0; i < 4; i++) add(0,1,0,0,2,0,0,5,1,'hF, 1,'b0100,2,1,0);
    add(0,1,0,0,2,0,0,5,1,'hF, 0,'b0100,2,1,0);
    add(0,1,0,0,2,0,0,5,1,'hF, 0,'b0000,2,1,1);
    add(0,1,0,0,2,0,0,5,1,'hF, 0,'b0000,2,0,0);
    // INTERLEAVE mask=1011 burst=2 tot=8
    add(0,1,1,1,0,'b1011,2,8,1,'hF, 0,'b0000,2,0,0);
    add(0,1,0,1,0,'b1011,2,8,1,'hF, 1,'b0000,0,1,0);
    add(0,1,0,1,0,'b1011,2,8,1,'hF, 1,'b0001,0,1,0);
    add(0,1,0,1,0,'b1011,2,8,1,'hF, 1,'b0001,1,1,0);
    add(0,1,0,1,0,'b1011,2,8,1,'hF, 1,'b0010,1,1,0);
    add(0,1,0,1,0,'b1011,2,8,1,'hF, 1,'b0010,3,1,0);
    add(0,1,0,1,0,'b1011,2,8,1,'hF, 1,'b1000,3,1,0);
    add(0,1,0,1,0,'b1011,2,8,1,'hF, 1,'b1000,0,1,0);
    add(0,1,0,1,0,'b1011,2,8,1,'hF, 1,'b0001,0,1,0);
    add(0,1,0,1,0,'b1011,2,8,1,'hF, 0,'b0001,1,1,0);
    add(0,1,0,1,0,'b1011,2,8,1,'hF, 0,'b0000,1,1,1);
    add(0,1,0,1,0,'b1011,2,8,1,'hF, 0,'b0000,1,0,0);
    // backpressure: STATIC sel=1 tot=4, ch1 stalled then released
    add(0,1,1,0,1,0,0,4,1,'b0000, 0,'b0000,1,0,0);
    add(0,1,0,0,1,0,0,4,1,'b0000, 1,'b0000,1,1,0);
    add(0,1,0,0,1,0,0,4,1,'b0000, 1,'b0010,1,1,0);
    add(0,1,0,0,1,0,0,4,1,'b0000, 0,'b0010,1,1,0);
    add(0,1,0,0,1,0,0,4,1,'b0010, 0,'b0010,1,1,0);
    add(0,1,0,0,1,0,0,4,1,'b0000, 1,'b0010,1,1,0);
    add(0,1,0,0,1,0,0,4,1,'b0010, 0,'b0010,1,1,0);
    add(0,1,0,0,1,0,0,4,1,'b0010, 1,'b0010,1,1,0);
    add(0,1,0,0,1,0,0,4,1,'b0010, 0,'b0010,1,1,0);
    add(0,1,0,0,1,0,0,4,1,'b0010, 0,'b0000,1,1,1);
    add(0,1,0,0,1,0,0,4,1,'b0010, 0,'b0000,1,0,0);
    // mask change mid-burst: mask=0110 burst=3 tot=6
    add(0,1,1,1,0,'b0110,3,6,1,'hF, 0,'b0000,1,0,0);
    add(0,1,0,1,0,'b0110,3,6,1,'hF, 1,'b0000,1,1,0);
    add(0,1,0,1,0,'b0100,3,6,1,'hF, 0,'b0010,1,1,0);
    add(0,1,0,1,0,'b0100,3,6,1,'hF, 1,'b0000,2,1,0);
    add(0,1,0,1,0,'b0110,3,6,1,'hF, 1,'b0100,2,1,0);
    add(0,1,0,1,0,'b0110,3,6,1,'hF, 1,'b0100,2,1,0);
    add(0,1,0,1,0,'b0110,3,6,1,'hF, 1,'b0100,1,1,0);
    add(0,1,0,1,0,'b0110,3,6,1,'hF, 1,'b0010,1,1,0);
    add(0,1,0,1,0,'b0110,3,6,1,'hF, 0,'b0010,1,1,0);
    add(0,1,0,1,0,'b0110,3,6,1,'hF, 0,'b0000,1,1,1);
    add(0,1,0,1,0,'b0110,3,6,1,'hF, 0,'b0000,1,0,0);
    // tot_len=0 and INTERLEAVE mask=0 ignore start
    add(0,1,1,0,0,0,1,0,1,'hF, 0,'b0000,1,0,0);
    add(0,1,0,0,0,0,1,0,1,'hF, 0,'b0000,1,0,0);
    add(0,1,1,1,0,0,1,4,1,'hF, 0,'b0000,1,0,0);
    add(0,1,0,1,0,0,1,4,1,'hF, 0,'b0000,1,0,0);
    // burst_len=0 acts as 1, mask=0101 tot=3
    add(0,1,1,1,0,'b0101,0,3,1,'hF, 0,'b0000,1,0,0);
    add(0,1,0,1,0,'b0101,0,3,1,'hF, 1,'b0000,0,1,0);
    add(0,1,0,1,0,'b0101,0,3,1,'hF, 1,'b0001,2,1,0);
    add(0,1,0,1,0,'b0101,0,3,1,'hF, 1,'b0100,0,1,0);
    add(0,1,0,1,0,'b0101,0,3,1,'hF, 0,'b0001,2,1,0);
    add(0,1,0,1,0,'b0101,0,3,1,'hF, 0,'b0000,2,1,1);
    add(0,1,0,1,0,'b0101,0,3,1,'hF, 0,'b0000,2,0,0);
    // STATIC sel 0->3 mid-job
    add(0,1,1,0,0,0,0,4,1,'hF, 0,'b0000,2,0,0);
    add(0,1,0,0,0,0,0,4,1,'hF, 1,'b0000,0,1,0);
    add(0,1,0,0,3,0,0,4,1,'hF, 1,'b0001,0,1,0);
    add(0,1,0,0,3,0,0,4,1,'hF, 1,'b0001,3,1,0);
    add(0,1,0,0,3,0,0,4,1,'hF, 1,'b1000,3,1,0);
    add(0,1,0,0,3,0,0,4,1,'hF, 0,'b1000,3,1,0);
    add(0,1,0,0,3,0,0,4,1,'hF, 0,'b0000,3,1,1);
    add(0,1,0,0,3,0,0,4,1,'hF, 0,'b0000,3,0,0);
    // enable low for 4 cycles, then clear after beat 3 of 8
    add(0,1,1,0,2,0,0,8,1,'hF, 0,'b0000,3,0,0);
    add(0,1,0,0,2,0,0,8,1,'hF, 1,'b0000,2,1,0);
    for (int i = 0; i < 4; i++) add(0,0,0,0,2,0,0,8,1,'hF, 0,'b0000,2,1,0);
    add(0,1,0,0,2,0,0,8,1,'hF, 1,'b0100,2,1,0);
    add(0,1,0,0,2,0,0,8,1,'hF, 1,'b0100,2,1,0);
    add(1,1,0,0,2,0,0,8,0,'hF, 1,'b0100,2,1,0);
    add(0,1,0,0,2,0,0,8,1,'hF, 0,'b0000,0,0,0);
    add(0,1,0,0,2,0,0,8,1,'hF, 0,'b0000,0,0,0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_push_ready", -1, bus.push_ready, 0);
    chk("rst_pop_valid", -1, bus.pop_valid, 0);
    chk("rst_pop_data", -1, bus.pop_data, 0);
    chk("rst_pop_strb", -1, bus.pop_strb, 0);
    chk("rst_busy", -1, busy, 0);
    chk("rst_done", -1, done, 0);
    chk("rst_cur_ch", -1, cur_ch, 0);
    chk("rst_empty", -1, f_empty, 4'hF);
    chk("rst_full", -1, f_full, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      clear = v.clr; enable = v.en; start = v.st; mode = v.md; sel = v.sel; mask = v.mask;
      blen = v.blen; tot = v.tot; bus.push_valid = v.pv; bus.pop_ready = v.pr;
      bus.push_data = 32'hD000_0000 | nb;
      bus.push_strb = nb[3:0] ^ 4'h5;
      #1;
      chk("push_ready", i, bus.push_ready, v.e_rdy);
      chk("pop_valid", i, bus.pop_valid, v.e_val);
      chk("cur_ch", i, cur_ch, v.e_ch);
      chk("busy", i, busy, v.e_busy);
      chk("done", i, done, v.e_done);
      for (int k = 0; k < NB; k++) begin
        if (v.e_val[k] && q[k].size() > 0) begin
          chk("pop_head", i, {bus.pop_data[k*DW +: DW], bus.pop_strb[k*4 +: 4]}, q[k][0]);
          if (v.pr[k]) void'(q[k].pop_front());
        end
      end
      if (v.e_rdy && v.pv) begin
        q[v.e_ch].push_back({bus.push_data, bus.push_strb});
        nb++;
      end
      if (v.clr) for (int k = 0; k < NB; k++) q[k].delete();
    end
    @(negedge clk);
    clear = 0; enable = 1; start = 1; mode = 0; sel = 1; tot = 2; bus.push_valid = 1; bus.pop_ready = 0;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("seq_full", -1, f_full, 4'b0010);
    chk("seq_empty", -1, f_empty, 4'b1101);
    chk("seq_ready_full", -1, bus.push_ready, 0);
    bus.pop_ready = 4'b0010;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      #1;
      seen = done;
    end
    chk("seq_done_seen", -1, seen, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
